calculator_button_conditioner: RTL

//  Upstream front end for the five calculator push-buttons (btnU/btnD/btnC/btnL/btnR).

---
 rtl/calculator_pkg.sv | 37 +++
 rtl/calculator_button_channel.sv | 191 +++++++++++++++++++
 rtl/calculator_button_conditioner.sv | 53 +++++
 3 files changed

// File: rtl/calculator_pkg.sv
// -----------------------------------------------------------------------------
// calculator_pkg
// Shared definitions for the calculator push-button front end.
//   btn_state_t  : per-channel debounce/hold state
//   BTN_U..BTN_R : bit positions of each button in the button vectors
//   cnt_width    : width of a counter that must reach a given terminal count
//   max3         : largest of three integers, used to size shared counters
// -----------------------------------------------------------------------------
package calculator_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_C = 2;
    localparam int BTN_L = 3;
    localparam int BTN_R = 4;

    // One spare bit above $clog2 so the counter can hold the terminal value itself.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/calculator_button_channel.sv
// -----------------------------------------------------------------------------
// calculator_button_channel
// One push-button: 2-flop synchroniser, debounce FSM, optional auto-repeat.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   raw            in   asynchronous raw button level
//   level          out  debounced level (1 = held)
//   press_pulse    out  one-cycle pulse on accepted press or auto-repeat
//   release_pulse  out  one-cycle pulse on accepted release
//
// All outputs are registered. The level register follows the FSM: it is high
// exactly while the channel sits in HELD or RELEASE_WAIT, so it changes on the
// same edge as the matching press/release pulse.
// -----------------------------------------------------------------------------
module calculator_button_channel
    import calculator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE));

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RD_LIMIT  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RR_LIMIT  = CNT_W'(REPEAT_RATE);

    logic             sync_p0;
    logic             sync_p1;

    btn_state_t       state;
    btn_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_next;
    logic             first_rep;
    logic             first_rep_next;

    logic             level_next;
    logic             press_next;
    logic             release_next;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rep_inc;
    logic             cnt_hit;
    logic             rep_hit;

    // ---- stage p0/p1: two-flop synchroniser; only sync_p1 feeds the FSM ----
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // "Would reach" comparisons: the transition happens on the edge where the
    // incremented value equals the limit, so the limit itself is never stored.
    always_comb begin
        cnt_inc = cnt + CNT_ONE;
        rep_inc = rep_cnt + CNT_ONE;
        cnt_hit = (cnt_inc == DB_LIMIT);
        rep_hit = (rep_inc == (first_rep ? RD_LIMIT : RR_LIMIT));
    end

    // ---- stage p2: FSM state and counters ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rep_cnt   <= '0;
            first_rep <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rep_cnt   <= rep_cnt_next;
            first_rep <= first_rep_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        rep_cnt_next   = rep_cnt;
        first_rep_next = first_rep;

        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (sync_p1) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end

            PRESS_WAIT: begin
                if (!sync_p1) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_hit) begin
                    state_next     = HELD;
                    cnt_next       = '0;
                    rep_cnt_next   = '0;
                    first_rep_next = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            HELD: begin
                if (!sync_p1) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end else if (REPEAT_EN) begin
                    if (rep_hit) begin
                        rep_cnt_next   = '0;
                        first_rep_next = 1'b0;
                    end else begin
                        rep_cnt_next = rep_inc;
                    end
                end
            end

            RELEASE_WAIT: begin
                // A bounce back to HELD keeps the repeat timer where it was so
                // contact chatter cannot postpone an auto-repeat indefinitely.
                if (sync_p1) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_hit) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            default: begin
                state_next     = IDLE;
                cnt_next       = '0;
                rep_cnt_next   = '0;
                first_rep_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        press_next   = 1'b0;
        release_next = 1'b0;
        level_next   = (state_next == HELD) || (state_next == RELEASE_WAIT);

        unique case (state)
            PRESS_WAIT:   press_next   = sync_p1 && cnt_hit;
            HELD:         press_next   = sync_p1 && REPEAT_EN && rep_hit;
            RELEASE_WAIT: release_next = !sync_p1 && cnt_hit;
            default: begin
                press_next   = 1'b0;
                release_next = 1'b0;
            end
        endcase
    end

    // ---- stage p3: registered outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            level         <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
        end
    end

endmodule

// File: rtl/calculator_button_conditioner.sv
// -----------------------------------------------------------------------------
// calculator_button_conditioner
// Front end for the five calculator push-buttons. Each button gets its own
// independent synchroniser + debounce + auto-repeat channel; this level only
// replicates the channel and merges the press pulses.
//
// Ports
//   IN_clk             in   system clock, rising edge
//   IN_reset           in   synchronous active-high reset
//   IN_raw_buttons     in   raw button levels, [0]=U [1]=D [2]=C [3]=L [4]=R
//   OUT_level          out  debounced levels (1 = held)
//   OUT_press_pulse    out  one-cycle press / auto-repeat pulses
//   OUT_release_pulse  out  one-cycle release pulses
//   OUT_any_press      out  OR of OUT_press_pulse in the same cycle
// -----------------------------------------------------------------------------
module calculator_button_conditioner
    import calculator_pkg::*;
#(
    parameter int                     NUM_BUTTONS     = 5,
    parameter int                     DEBOUNCE_CYCLES = 1_000_000,
    parameter int                     REPEAT_DELAY    = 50_000_000,
    parameter int                     REPEAT_RATE     = 10_000_000,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = 5'b00011
) (
    input  logic                   IN_clk,
    input  logic                   IN_reset,
    input  logic [NUM_BUTTONS-1:0] IN_raw_buttons,
    output logic [NUM_BUTTONS-1:0] OUT_level,
    output logic [NUM_BUTTONS-1:0] OUT_press_pulse,
    output logic [NUM_BUTTONS-1:0] OUT_release_pulse,
    output logic                   OUT_any_press
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        calculator_button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .clk           (IN_clk),
            .reset         (IN_reset),
            .raw           (IN_raw_buttons[i]),
            .level         (OUT_level[i]),
            .press_pulse   (OUT_press_pulse[i]),
            .release_pulse (OUT_release_pulse[i])
        );
    end

    // The pulses are already registered, so this OR is aligned with them.
    assign OUT_any_press = |OUT_press_pulse;

endmodule
